// File: rtl/obi_demux_1_to_2.sv
// OBI 1-to-2 address demux with outstanding-read tracking.
// Optional internal decode-error slave enabled by OBI_DEMUX_ERR_EN.
module obi_demux_1_to_2 #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000,
    parameter int          DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mst_req_i,
    output logic        mst_gnt_o,
    input  logic [31:0] mst_addr_i,
    input  logic        mst_we_i,
    input  logic [3:0]  mst_be_i,
    input  logic [31:0] mst_wdata_i,
    output logic        mst_rvalid_o,
    output logic [31:0] mst_rdata_o,
    output logic        s0_req_o,
    input  logic        s0_gnt_i,
    output logic [31:0] s0_addr_o,
    output logic        s0_we_o,
    output logic [3:0]  s0_be_o,
    output logic [31:0] s0_wdata_o,
    input  logic        s0_rvalid_i,
    input  logic [31:0] s0_rdata_i,
    output logic        s1_req_o,
    input  logic        s1_gnt_i,
    output logic [31:0] s1_addr_o,
    output logic        s1_we_o,
    output logic [3:0]  s1_be_o,
    output logic [31:0] s1_wdata_o,
    input  logic        s1_rvalid_i,
    input  logic [31:0] s1_rdata_i,
    output logic        err_o,
    output logic        bad_state_o
);

    localparam logic [1:0]  T_S0  = 2'd0;
    localparam logic [1:0]  T_S1  = 2'd1;
    localparam logic [1:0]  T_ERR = 2'd2;
    localparam logic [2:0]  DMAX  = 3'(DEPTH);
    localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

    logic [2:0]  cnt;
    logic [1:0]  cur_tgt;
    logic [1:0]  tgt;
    logic        hit0;
    logic        hit1;
    logic        eligible;
    logic        sel_gnt;
    logic        rd_hs;
    logic        cur_rvalid;
    logic [31:0] cur_rdata;
    logic        err_rvalid;

    assign hit0 = (mst_addr_i & S0_MASK) == S0_BASE;
    assign hit1 = (mst_addr_i & S1_MASK) == S1_BASE;

`ifdef OBI_DEMUX_ERR_EN
    assign tgt = hit0 ? T_S0 : (hit1 ? T_S1 : T_ERR);
`else
    assign tgt = (hit1 && !hit0) ? T_S1 : T_S0;
`endif

    assign eligible = mst_we_i || (cnt == 3'd0) ||
                      ((cnt < DMAX) && (tgt == cur_tgt));

    assign s0_req_o = mst_req_i && (tgt == T_S0) && eligible;
    assign s1_req_o = mst_req_i && (tgt == T_S1) && eligible;

    assign s0_addr_o  = mst_addr_i;
    assign s0_we_o    = mst_we_i;
    assign s0_be_o    = mst_be_i;
    assign s0_wdata_o = mst_wdata_i;
    assign s1_addr_o  = mst_addr_i;
    assign s1_we_o    = mst_we_i;
    assign s1_be_o    = mst_be_i;
    assign s1_wdata_o = mst_wdata_i;

    // The error slave grants whenever it is addressed.
    always_comb begin
        sel_gnt = 1'b0;
        case (tgt)
            T_S0:    sel_gnt = s0_gnt_i;
            T_S1:    sel_gnt = s1_gnt_i;
            default: sel_gnt = mst_req_i;
        endcase
    end

    assign mst_gnt_o = sel_gnt && eligible;
    assign rd_hs     = mst_req_i && mst_gnt_o && !mst_we_i;

    always_comb begin
        cur_rvalid = 1'b0;
        cur_rdata  = 32'h0;
        case (cur_tgt)
            T_S0: begin
                cur_rvalid = s0_rvalid_i;
                cur_rdata  = s0_rdata_i;
            end
            T_S1: begin
                cur_rvalid = s1_rvalid_i;
                cur_rdata  = s1_rdata_i;
            end
            default: begin
                cur_rvalid = err_rvalid;
                cur_rdata  = ERR_DATA;
            end
        endcase
    end

    assign mst_rvalid_o = (cnt != 3'd0) && cur_rvalid;
    assign mst_rdata_o  = (cnt != 3'd0) ? cur_rdata : 32'h0;

    assign bad_state_o = ((cnt == 3'd0) && (s0_rvalid_i || s1_rvalid_i)) ||
                         (s0_rvalid_i && (cur_tgt != T_S0)) ||
                         (s1_rvalid_i && (cur_tgt != T_S1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= 3'd0;
            cur_tgt <= T_S0;
        end else begin
            if (rd_hs) begin
                cur_tgt <= tgt;
            end
            if (rd_hs && !mst_rvalid_o) begin
                cnt <= cnt + 3'd1;
            end else if (!rd_hs && mst_rvalid_o) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

`ifdef OBI_DEMUX_ERR_EN
    // Fixed one-cycle read latency for the error slave.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_rvalid <= 1'b0;
        end else begin
            err_rvalid <= rd_hs && (tgt == T_ERR);
        end
    end

    assign err_o = mst_req_i && (tgt == T_ERR) && eligible;
`else
    assign err_rvalid = 1'b0;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_obi_demux_1_to_2.sv
// Directed bench for obi_demux_1_to_2; read data checked by a
// scoreboard queue popped by an independent response monitor.
module tb_obi_demux_1_to_2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mst_req_i;
    logic        mst_gnt_o;
    logic [31:0] mst_addr_i;
    logic        mst_we_i;
    logic [3:0]  mst_be_i;
    logic [31:0] mst_wdata_i;
    logic        mst_rvalid_o;
    logic [31:0] mst_rdata_o;
    logic        s0_req_o, s0_gnt_i, s0_we_o, s0_rvalid_i;
    logic [31:0] s0_addr_o, s0_wdata_o, s0_rdata_i;
    logic [3:0]  s0_be_o;
    logic        s1_req_o, s1_gnt_i, s1_we_o, s1_rvalid_i;
    logic [31:0] s1_addr_o, s1_wdata_o, s1_rdata_i;
    logic [3:0]  s1_be_o;
    logic        err_o;
    logic        bad_state_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    bit done = 0;

    always #5 clk_i = ~clk_i;

    obi_demux_1_to_2 dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mst_req_i(mst_req_i), .mst_gnt_o(mst_gnt_o),
        .mst_addr_i(mst_addr_i), .mst_we_i(mst_we_i),
        .mst_be_i(mst_be_i), .mst_wdata_i(mst_wdata_i),
        .mst_rvalid_o(mst_rvalid_o), .mst_rdata_o(mst_rdata_o),
        .s0_req_o(s0_req_o), .s0_gnt_i(s0_gnt_i),
        .s0_addr_o(s0_addr_o), .s0_we_o(s0_we_o),
        .s0_be_o(s0_be_o), .s0_wdata_o(s0_wdata_o),
        .s0_rvalid_i(s0_rvalid_i), .s0_rdata_i(s0_rdata_i),
        .s1_req_o(s1_req_o), .s1_gnt_i(s1_gnt_i),
        .s1_addr_o(s1_addr_o), .s1_we_o(s1_we_o),
        .s1_be_o(s1_be_o), .s1_wdata_o(s1_wdata_o),
        .s1_rvalid_i(s1_rvalid_i), .s1_rdata_i(s1_rdata_i),
        .err_o(err_o), .bad_state_o(bad_state_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk_i);
        mst_req_i = 0; mst_we_i = 0; mst_addr_i = 0;
        s0_gnt_i = 0; s1_gnt_i = 0;
        s0_rvalid_i = 0; s1_rvalid_i = 0;
        s0_rdata_i = 32'hDEAD_0000; s1_rdata_i = 32'hDEAD_1111;
    endtask

    task automatic rd(input logic [31:0] a, input logic g0, input logic g1);
        @(negedge clk_i);
        mst_req_i = 1; mst_we_i = 0; mst_addr_i = a;
        s0_gnt_i = g0; s1_gnt_i = g1;
        s0_rvalid_i = 0; s1_rvalid_i = 0;
        #1;
    endtask

    // Response monitor: every routed rvalid must match the queue head.
    always @(negedge clk_i) begin
        #2;
        if (!done && mst_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: rdata %h with empty queue",
                         mst_rdata_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (mst_rdata_o !== e) begin
                    failures++;
                    $display("FAIL rsp_data: got %h expected %h",
                             mst_rdata_o, e);
                end
            end
        end
    end

    initial begin
        rst_i = 1;
        mst_be_i = 4'hF; mst_wdata_i = 32'h5555_AAAA;
        mst_req_i = 0; mst_we_i = 0; mst_addr_i = 0;
        s0_gnt_i = 0; s1_gnt_i = 0; s0_rvalid_i = 0; s1_rvalid_i = 0;
        s0_rdata_i = 0; s1_rdata_i = 0;
        @(negedge clk_i); @(negedge clk_i);
        #1;
        chk("rst_gnt", mst_gnt_o, 0);
        chk("rst_rvalid", mst_rvalid_o, 0);
        chk("rst_bad", bad_state_o, 0);
        chk("rst_err", err_o, 0);
        idle();
        rst_i = 0;
        #1 chk("idle_rdata_zero", mst_rdata_o, 0);

        // single read to s0, response two cycles later
        rd(32'h0000_0010, 1, 0);
        chk("r1_s0_req", s0_req_o, 1);
        chk("r1_s1_req", s1_req_o, 0);
        chk("r1_gnt", mst_gnt_o, 1);
        exp_q.push_back(32'h1234_5678);
        idle();
        idle();
        s0_rvalid_i = 1; s0_rdata_i = 32'h1234_5678;
        #1 chk("r1_rvalid", mst_rvalid_o, 1);
        // cnt back to 0: s1 read granted at once
        rd(32'h8000_0004, 0, 1);
        chk("r1_cnt0_s1_gnt", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_00A1);
        idle();
        s1_rvalid_i = 1; s1_rdata_i = 32'h0000_00A1;

        // target switch stalls until outstanding read drains
        rd(32'h0000_0100, 1, 0);
        chk("sw_s0_gnt", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0D01);
        rd(32'h8000_0004, 0, 1);
        chk("sw_stall_gnt", mst_gnt_o, 0);
        chk("sw_stall_req", s1_req_o, 0);
        rd(32'h8000_0004, 0, 1);
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0D01;
        #1;
        chk("sw_nobypass_gnt", mst_gnt_o, 0);
        chk("sw_nobypass_req", s1_req_o, 0);
        rd(32'h8000_0004, 0, 1);
        chk("sw_s1_req", s1_req_o, 1);
        chk("sw_s1_gnt", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0D02);
        idle();
        s1_rvalid_i = 1; s1_rdata_i = 32'h0000_0D02;

        // depth limit: third read stalls
        rd(32'h0000_0020, 1, 0);
        chk("dp_gnt1", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0003);
        rd(32'h0000_0024, 1, 0);
        chk("dp_gnt2", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0004);
        rd(32'h0000_0028, 1, 0);
        chk("dp_gnt3_stall", mst_gnt_o, 0);
        chk("dp_req3_stall", s0_req_o, 0);
        rd(32'h0000_0028, 1, 0);
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0003;
        #1 chk("dp_full_nobypass", mst_gnt_o, 0);
        rd(32'h0000_0028, 1, 0);
        chk("dp_gnt3", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0005);
        idle();
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0004;
        idle();
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0005;

        // write to s1 passes while s0 read outstanding
        rd(32'h0000_0030, 1, 0);
        exp_q.push_back(32'h0000_0006);
        @(negedge clk_i);
        mst_req_i = 1; mst_we_i = 1; mst_addr_i = 32'h8000_0000;
        s0_gnt_i = 0; s1_gnt_i = 1;
        #1;
        chk("wr_s1_req", s1_req_o, 1);
        chk("wr_s0_req", s0_req_o, 0);
        chk("wr_gnt", mst_gnt_o, 1);
        chk("wr_s1_we", s1_we_o, 1);
        idle();
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0006;
        #1 chk("wr_cnt_kept", mst_rvalid_o, 1);

        // unmapped address
`ifdef OBI_DEMUX_ERR_EN
        rd(32'h4000_0000, 0, 0);
        chk("um_gnt", mst_gnt_o, 1);
        chk("um_err", err_o, 1);
        chk("um_s0_req", s0_req_o, 0);
        exp_q.push_back(32'hBADC_0DE5);
        idle();
        #1 chk("um_rvalid", mst_rvalid_o, 1);
        idle();
        #1 chk("um_err_pulse", err_o, 0);
`else
        rd(32'h4000_0000, 1, 0);
        chk("um_s0_req", s0_req_o, 1);
        chk("um_s1_req", s1_req_o, 0);
        chk("um_gnt", mst_gnt_o, 1);
        chk("um_err", err_o, 0);
        exp_q.push_back(32'h0000_0007);
        idle();
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0007;
`endif

        // stray rvalid with nothing outstanding
        idle();
        s1_rvalid_i = 1; s1_rdata_i = 32'h0000_BEEF;
        #1;
        chk("stray_bad", bad_state_o, 1);
        chk("stray_rvalid", mst_rvalid_o, 0);
        idle();
        #1 chk("stray_bad_clr", bad_state_o, 0);
        rd(32'h8000_0008, 0, 1);
        chk("stray_cnt0", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_0008);
        idle();
        s1_rvalid_i = 1; s1_rdata_i = 32'h0000_0008;

        // rvalid from the non-current slave, then reset mid-read
        rd(32'h0000_0040, 1, 0);
        exp_q.push_back(32'h0000_0009);
        idle();
        s1_rvalid_i = 1;
        #1;
        chk("wrong_slv_bad", bad_state_o, 1);
        chk("wrong_slv_rvalid", mst_rvalid_o, 0);
        idle();
        rst_i = 1;
        s0_rvalid_i = 1; s0_rdata_i = 32'h0000_0009;
        void'(exp_q.pop_front());
        #1;
        chk("rst_mid_rvalid", mst_rvalid_o, 0);
        chk("rst_mid_bad", bad_state_o, 1);
        idle();
        rst_i = 0;
        rd(32'h8000_000C, 0, 1);
        chk("rst_cnt0_gnt", mst_gnt_o, 1);
        exp_q.push_back(32'h0000_000A);
        idle();
        s1_rvalid_i = 1; s1_rdata_i = 32'h0000_000A;
        idle();
        idle();
        #1;
        chk("queue_empty", exp_q.size(), 0);
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
